// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;
  localparam int DW    = 16;
  localparam int VW    = 8;
  localparam int CNT_W = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and report that as the quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [VW-1:0] rem_i,
  input  logic          msb_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW-1:0] rem_o,
  output logic          qbit_o
);
  logic [VW:0] trial;

  // rem_i < divisor, so trial < 2*divisor and the difference fits in VW bits
  always_comb begin
    trial  = {rem_i, msb_i};
    qbit_o = (trial >= {1'b0, divisor_i});
    rem_o  = qbit_o ? VW'(trial - {1'b0, divisor_i}) : trial[VW-1:0];
  end
endmodule

// File: rtl/div16x8_seq.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per clock,
// valid/ready on both sides; divide-by-zero answers in one cycle.
module div16x8_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DW - 1);

  state_t           state_q, state_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [VW-1:0]    rem_q, rem_d;
  logic [VW-1:0]    dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             accept;
  logic [VW-1:0]    step_rem;
  logic             step_qbit;

  assign accept = in_valid && (state_q == IDLE);

  div_step u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt_q == LAST_STEP) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Dividend register doubles as the quotient: quotient bits enter at the LSB
  // as dividend bits leave at the MSB.
  always_comb begin
    dvd_d = dvd_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvs_d = divisor;
      cnt_d = '0;
      if (divisor == '0) begin
        dvd_d = '1;
        rem_d = dividend[VW-1:0];
        dbz_d = 1'b1;
      end else begin
        dvd_d = dividend;
        rem_d = '0;
        dbz_d = 1'b0;
      end
    end else if (state_q == CALC) begin
      dvd_d = {dvd_q[DW-2:0], step_qbit};
      rem_d = step_rem;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient    = dvd_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
